// File: rtl/data_mem_sync.sv
// Clocked single-port data memory with self-initialisation and a valid/ready host port.
// Optional access counters are built when DATA_MEM_SYNC_STATS_EN is defined.
module data_mem_sync #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int INIT_ADDR = 18,
  parameter int INIT_VAL  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              addr_err,
  output logic              init_done,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  // state  | meaning
  // INIT   | sweeping init_cnt over every word, host port closed
  // IDLE   | memory initialised, one request accepted per cycle

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_IDLE = 1'b1;

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C   = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] INIT_A_C = (ADDR_W+1)'(INIT_ADDR);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W:0]   init_cnt;
  logic              accept;
  logic              acc_rd;
  logic              acc_wr;
  logic              in_range;
  logic [DATA_W-1:0] init_word;

  assign req_ready = (state == S_IDLE);
  assign init_done = (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign acc_rd    = accept && req_op;
  assign acc_wr    = accept && !req_op;
  assign in_range  = ({1'b0, req_addr} < DEPTH_C);
  assign init_word = (init_cnt == INIT_A_C) ? DATA_W'(INIT_VAL) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else if (state == S_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST_C) state <= S_IDLE;
    end
  end

  // No reset on the array itself so it can map onto a RAM macro; INIT rewrites it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_INIT)
        mem[init_cnt[ADDR_W-1:0]] <= init_word;
      else if (acc_wr && in_range)
        mem[req_addr] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= acc_rd;
      addr_err <= accept && !in_range;
      if (acc_rd) data_out <= in_range ? mem[req_addr] : '0;
    end
  end

`ifdef DATA_MEM_SYNC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (acc_rd && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (acc_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync: a full-depth instance and a DEPTH=200 instance share one stimulus
// stream and are compared against array-based reference memories.
module tb_data_mem_sync;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_op = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;

  logic        a_ready, a_rv, a_err, a_init;
  logic [7:0]  a_data;
  logic [15:0] a_rdc, a_wrc;
  logic        b_ready, b_rv, b_err, b_init;
  logic [7:0]  b_data;
  logic [15:0] b_rdc, b_wrc;

  always #5 clk = ~clk;

  data_mem_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_ADDR(18), .INIT_VAL(3)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(a_ready),
    .data_out(a_data), .rd_valid(a_rv), .addr_err(a_err), .init_done(a_init),
    .rd_count(a_rdc), .wr_count(a_wrc));

  data_mem_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .INIT_ADDR(18), .INIT_VAL(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(b_ready),
    .data_out(b_data), .rd_valid(b_rv), .addr_err(b_err), .init_done(b_init),
    .rd_count(b_rdc), .wr_count(b_wrc));

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [200];
  logic [7:0] ea_data, eb_data;
  logic       ea_rv, ea_err, eb_rv, eb_err;
  int         ea_rd, ea_wr, eb_rd, eb_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_exp(input int n);
`ifdef DATA_MEM_SYNC_STATS_EN
    return (n > 65535) ? 65535 : n;
`else
    return 0 * n;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) mem_a[i] = (i == 18) ? 8'd3 : 8'd0;
    for (int i = 0; i < 200; i++) mem_b[i] = (i == 18) ? 8'd3 : 8'd0;
    ea_data = 0; eb_data = 0;
    ea_rv = 0; ea_err = 0; eb_rv = 0; eb_err = 0;
    ea_rd = 0; ea_wr = 0; eb_rd = 0; eb_wr = 0;
  endfunction

  task automatic check_all(input logic exp_ready);
    chk("a_ready",   32'(a_ready), 32'(exp_ready));
    chk("a_init",    32'(a_init),  32'(exp_ready));
    chk("a_data",    32'(a_data),  32'(ea_data));
    chk("a_rd_valid",32'(a_rv),    32'(ea_rv));
    chk("a_addr_err",32'(a_err),   32'(ea_err));
    chk("a_rd_count",32'(a_rdc),   32'(cnt_exp(ea_rd)));
    chk("a_wr_count",32'(a_wrc),   32'(cnt_exp(ea_wr)));
    chk("b_ready",   32'(b_ready), 32'(exp_ready));
    chk("b_data",    32'(b_data),  32'(eb_data));
    chk("b_rd_valid",32'(b_rv),    32'(eb_rv));
    chk("b_addr_err",32'(b_err),   32'(eb_err));
    chk("b_rd_count",32'(b_rdc),   32'(cnt_exp(eb_rd)));
    chk("b_wr_count",32'(b_wrc),   32'(cnt_exp(eb_wr)));
  endtask

  // One host cycle after init: predict both memories' responses, apply, then check.
  task automatic cycle(input logic v, input logic op, input logic [7:0] a, input logic [7:0] d);
    req_valid = v; req_op = op; req_addr = a; req_wdata = d;
    ea_rv = 0; ea_err = 0; eb_rv = 0; eb_err = 0;
    if (v) begin
      if (op) begin
        ea_data = mem_a[a]; ea_rv = 1; ea_rd++;
        eb_rv = 1; eb_rd++;
        if (a < 200) eb_data = mem_b[a];
        else begin eb_data = 0; eb_err = 1; end
      end else begin
        mem_a[a] = d; ea_wr++; eb_wr++;
        if (a < 200) mem_b[a] = d;
        else eb_err = 1;
      end
    end
    @(posedge clk); #1;
    req_valid = 0;
    check_all(1'b1);
  endtask

  task automatic apply_reset(input int ncyc);
    reset = 1'b1;
    for (int i = 0; i < ncyc; i++) begin @(posedge clk); #1; end
    model_reset();
    check_all(1'b0);
    reset = 1'b0;
  endtask

  // Counts edges until each instance opens its port; optionally holds a write to addr 2 meanwhile.
  task automatic wait_init(input logic hold_req);
    int n = 0;
    int nb = -1;
    while (!a_ready && n < 400) begin
      req_valid = hold_req && (n < 150);
      req_op = 1'b0; req_addr = 8'd2; req_wdata = 8'hAA;
      @(posedge clk); #1;
      n++;
      if (b_ready && nb < 0) nb = n;
    end
    req_valid = 1'b0;
    chk("init_len_a", 32'(n), 32'd256);
    chk("init_len_b", 32'(nb), 32'd200);
  endtask

  initial begin
    model_reset();
    req_valid = 1'b1; req_op = 1'b0; req_addr = 8'd2; req_wdata = 8'hAA;
    apply_reset(2);
    wait_init(1'b1);

    cycle(1, 1, 8'd2, 8'h00);
    cycle(1, 1, 8'd18, 8'h00);
    cycle(1, 1, 8'd1, 8'h00);
    cycle(0, 0, 8'd0, 8'h00);
    cycle(1, 0, 8'd1, 8'h05);
    cycle(1, 1, 8'd1, 8'h00);
    cycle(1, 0, 8'd220, 8'h77);
    cycle(1, 1, 8'd220, 8'h00);
    cycle(1, 1, 8'd199, 8'h00);
    cycle(0, 0, 8'd0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      logic       v, op;
      logic [7:0] a, d;
      v  = ($urandom_range(0, 3) != 0);
      op = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      cycle(v, op, a, d);
    end

    cycle(1, 0, 8'd5, 8'h5A);
    cycle(1, 1, 8'd5, 8'h00);
    req_valid = 1'b1; req_op = 1'b1; req_addr = 8'd5;
    apply_reset(1);
    for (int i = 0; i < 100; i++) begin @(posedge clk); #1; end
    chk("mid_init_ready", 32'(a_ready), 32'd0);
    apply_reset(1);
    wait_init(1'b0);

    cycle(1, 1, 8'd5, 8'h00);
    cycle(1, 1, 8'd18, 8'h00);
    cycle(1, 1, 8'd220, 8'h00);
    cycle(0, 0, 8'd0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
